multu_hilo: RTL
===============

Name: multu_hilo

Overview:
- Iterative unsigned multiply unit with architectural HI/LO registers.
- Sits beside the ALU in the datapath and consumes the multiply-start and HI/LO-select controls produced by ALU control decoding (multu, mfhi, mflo).
- Computes a WIDTH x WIDTH unsigned product by shift-add, one bit per cycle.
- Commits the product atomically to HI/LO and returns HI, LO or zero on a result bus according to the select code.

Parameters:
WIDTH, 32, operand width; product is 2*WIDTH bits, HI = upper WIDTH bits, LO = lower WIDTH bits.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous reset, active low.
start  input  1  multiply request (driven by Multu decode); level-sampled each cycle.
src_a  input  WIDTH  multiplicand (rs).
src_b  input  WIDTH  multiplier (rt).
sel  input  2  result select: 2'b01 = HI, 2'b10 = LO, 2'b00 and 2'b11 = zero.
busy  output  1  multiply in progress.
done  output  1  one-cycle pulse when HI/LO have just been updated.
hi  output  WIDTH  HI register.
lo  output  WIDTH  LO register.
dout  output  WIDTH  selected result (HI, LO or 0 per sel); combinational from registers and sel.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; busy = 0; done = 0; hi = 0; lo = 0.
  - Counter and internal accumulator/operand registers are cleared.
  - Reset mid-operation aborts the multiply; HI/LO do not receive a partial product.
- FSM states: IDLE, RUN.
- IDLE:
  - On the edge where start = 1, latch mcand = src_a, and load acc = {WIDTH'b0, src_b} (2*WIDTH bits, multiplier in the low half).
  - Same edge: count = 0, go to RUN.
  - start = 0: stay in IDLE, all registers hold.
- RUN, each edge:
  - If acc[0] = 1, sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand} (WIDTH+1 bits, carry kept); else sum = {1'b0, acc upper half}.
  - acc <= {sum, acc[WIDTH-1:1]}, i.e. a right shift of carry:sum:low-half.
  - count <= count + 1.
  - On the edge where count = WIDTH-1 (the WIDTH-th iteration): hi <= final upper half, lo <= final lower half, done <= 1, state <= IDLE.
- Latency: start sampled at edge k -> busy high from edge k through edge k+WIDTH (WIDTH cycles).
  - HI/LO updated and done high after edge k+WIDTH.
  - done drops at edge k+WIDTH+1 unless another completion occurs.
- busy = (state == RUN); registered state decode, no combinational path from start.
- start while busy: ignored; operands are not re-latched and the running operation is unaffected.
- start in the done cycle: accepted, since state is IDLE; a back-to-back multiply begins and HI/LO keep the just-committed value until the next completion.
- HI/LO hold their previous values for the whole of RUN; mfhi/mflo issued during RUN read the old product.
- dout is purely combinational, with zero cycles of latency from sel or a register change.
- Arithmetic is unsigned only; no overflow is possible because the full 2*WIDTH product is kept.
- No X outputs after reset under any input sequence; unknown sel values map to 0.

Test Plan:
- Reset, then src_a=3, src_b=5, start pulsed one cycle -> busy high 32 cycles; done pulses once; hi=0, lo=15; sel=01 gives dout=0, sel=10 gives dout=15.
- src_a=src_b=32'hFFFFFFFF -> after 32 cycles hi=32'hFFFFFFFE, lo=32'h00000001; sel=11 gives dout=0.
- Start 7x9; at cycle 10 of RUN drive start=1 with src_a=2, src_b=2 -> ignored; result hi=0, lo=63; done pulses exactly once.
- Complete 7x9, then in the done cycle start 32'h10000 x 32'h10000 -> lo stays 63 for 32 cycles, then hi=1, lo=0.
- Start 32'h12345678 x 32'h9ABCDEF0, assert rst_n low at RUN cycle 15 -> busy=0, done=0, hi=lo=0 immediately (asynchronously); after release a new 2x3 gives lo=6.
- First commit 6x7 (lo=42), then multiply 0 x 32'hDEADBEEF -> lo stays 42 throughout RUN, then hi=0, lo=0 at completion.

Source files
------------

// File: rtl/multu_hilo.sv
// Iterative unsigned shift-add multiplier with architectural HI/LO registers.
// One multiplier bit is retired per cycle; the product is committed to HI/LO atomically.
//
// state | meaning
// IDLE  | waiting for start; HI/LO hold the last committed product
// RUN   | shift-add iterations in progress; HI/LO still hold the previous product
module multu_hilo #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [1:0]       sel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] dout
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t             state_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               done_q;

  logic [WIDTH:0]     sum_d;
  logic [2*WIDTH-1:0] acc_d;

  // Carry out of the upper-half add is kept and shifted back into the accumulator.
  always_comb begin
    sum_d = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    if (acc_q[0]) begin
      sum_d = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
    end
    acc_d = {sum_d, acc_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            mcand_q <= src_a;
            acc_q   <= {{WIDTH{1'b0}}, src_b};
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            hi_q    <= acc_d[2*WIDTH-1:WIDTH];
            lo_q    <= acc_d[WIDTH-1:0];
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

  always_comb begin
    dout = '0;
    case (sel)
      2'b01:   dout = hi_q;
      2'b10:   dout = lo_q;
      default: dout = '0;
    endcase
  end

endmodule
